// File: rtl/restoring_divider_pkg.sv
//==============================================================================
// Module      : restoring_divider_pkg
// Description : Shared constants for the restoring divider: state encoding,
//               default operand width and divide-by-zero quotient fill.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package restoring_divider_pkg;

    localparam int c_default_width = 16;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Quotient is replicated from this bit on divide-by-zero (all-ones result)
    localparam logic c_dbz_fill = 1'b1;

endpackage : restoring_divider_pkg

`default_nettype wire

// File: rtl/restoring_divider_trial_subtractor.sv
//==============================================================================
// Module      : restoring_divider_trial_subtractor
// Description : Combinational a - b as a + ~b + 1; borrow is the inverted
//               carry-out, matching the adder blocks' carry-chain style.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module restoring_divider_trial_subtractor #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] w_sum;

    assign w_sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign diff   = w_sum[WIDTH-1:0];
    assign borrow = ~w_sum[WIDTH];

endmodule : restoring_divider_trial_subtractor

`default_nettype wire

// File: rtl/restoring_divider.sv
//==============================================================================
// Module      : restoring_divider
// Description : Multi-cycle unsigned shift-and-subtract divider, one quotient
//               bit per clock, with start/busy/done handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_unused_rem_msb;

    assign w_accept   = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Remainder never exceeds the divisor after a step, so its MSB is always 0
    // going into the next shift; it exists only to make the borrow exact.
    assign w_unused_rem_msb = r_rem[WIDTH];
    assign w_rem_sh         = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};

    restoring_divider_trial_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_trial_subtractor (
        .a      (w_rem_sh),
        .b      ({1'b0, r_div}),
        .diff   (w_trial),
        .borrow (w_borrow)
    );

    assign w_rem_nxt = w_borrow ? w_rem_sh : w_trial;
    assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nxt = w_div_zero ? c_st_done : c_st_run;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_run: begin
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        busy = (r_state == c_st_run);
        done = (r_state == c_st_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quotient  <= {WIDTH{c_dbz_fill}};
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_q   <= dividend;
                r_div <= divisor;
                r_rem <= '0;
                r_cnt <= '0;
            end
        end else if (r_state == c_st_run) begin
            r_q   <= w_q_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            // Published results change only on completion, never mid-run
            if (w_last) begin
                r_quotient  <= w_q_nxt;
                r_remainder <= w_rem_nxt[WIDTH-1:0];
                r_dbz       <= 1'b0;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule : restoring_divider

`default_nettype wire

// File: tb/tb_restoring_divider.sv
//==============================================================================
// Module      : tb_restoring_divider
// Description : Self-checking bench for restoring_divider: vector table,
//               scoreboard queue, and hand sequences for multi-cycle corners.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_restoring_divider;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int   n_vec;
    int   n_err;
    vec_t sb[$];
    logic [15:0] last_q;

    restoring_divider #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                chk("remainder", {16'd0, remainder}, {16'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
            end
        end
    end

    task automatic run_div(input vec_t v);
        int cyc  = 0;
        int bcyc = 0;
        bit seen = 1'b0;
        @(posedge clk); #1;
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) bcyc++;
            if (cyc == 1 && v.z == 1'b0) chk("run_hold_q", {16'd0, quotient}, {16'd0, last_q});
            if (done) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("latency", cyc, v.z ? 32'd1 : 32'd17);
        chk("busy_cycles", bcyc, v.z ? 32'd0 : 32'd16);
        @(negedge clk);
        chk("done_width", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("hold_q", {16'd0, quotient}, {16'd0, v.q});
        last_q = v.q;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t v;
        int   cyc;
        bit   seen;

        n_vec = 0; n_err = 0; last_q = 16'd0;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

        tbl[0] = '{16'd100,   16'd7,     16'd14,    16'd2, 1'b0};
        tbl[1] = '{16'd65535, 16'd1,     16'd65535, 16'd0, 1'b0};
        tbl[2] = '{16'd65535, 16'd65535, 16'd1,     16'd0, 1'b0};
        tbl[3] = '{16'd3,     16'd10,    16'd0,     16'd3, 1'b0};
        tbl[4] = '{16'd0,     16'd5,     16'd0,     16'd0, 1'b0};
        tbl[5] = '{16'd5,     16'd0,     16'hFFFF,  16'd5, 1'b1};
        tbl[6] = '{16'd40000, 16'd300,   16'd133,   16'd100, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_q", {16'd0, quotient}, 32'd0);
        chk("rst_r", {16'd0, remainder}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_div(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            v.a = 16'($urandom_range(0, 65535));
            v.b = 16'($urandom_range(1, 300));
            v.q = v.a / v.b;
            v.r = v.a % v.b;
            v.z = 1'b0;
            run_div(v);
        end

        // Start during RUN is ignored; start during DONE is accepted
        @(posedge clk); #1;
        dividend = 16'd1000; divisor = 16'd9; start = 1'b1;
        sb.push_back('{16'd1000, 16'd9, 16'd111, 16'd1, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dividend = 16'd7; divisor = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        chk("ign_done_seen", {31'd0, seen}, 32'd1);
        chk("ign_latency", cyc, 32'd11);
        start = 1'b1;
        sb.push_back('{16'd7, 16'd2, 16'd3, 16'd1, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        chk("b2b_done_seen", {31'd0, seen}, 32'd1);
        chk("b2b_latency", cyc, 32'd17);
        @(negedge clk);
        last_q = 16'd3;

        // Reset in the middle of an operation aborts it with no done
        @(posedge clk); #1;
        dividend = 16'd500; divisor = 16'd3; start = 1'b1;
        sb.push_back('{16'd500, 16'd3, 16'd166, 16'd2, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", {16'd0, quotient}, 32'd0);
        chk("abort_r", {16'd0, remainder}, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("no_done_after_abort", {31'd0, seen}, 32'd0);
        last_q = 16'd0;
        run_div('{16'd500, 16'd3, 16'd166, 16'd2, 1'b0});

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_restoring_divider

`default_nettype wire
